// File: rtl/mem_pkg.sv
// Block-transfer types shared by the L1 caches, the memory arbiter and main memory.
package mem_pkg;

    typedef struct packed {
        logic         Valid;
        logic         Wen;
        logic [31:0]  Addr;
        logic [127:0] WriteD;
    } CacheToMem_t;

    typedef struct packed {
        logic         Ready;
        logic [127:0] ReadD;
    } MemToCache_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the main-memory block port between the I-cache and D-cache.
// One transaction at a time: IDLE -> BUSY_x (until memory Ready) -> RESP_x (1-cycle Ready pulse).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  CacheToMem_t ic_req_i,
    input  CacheToMem_t dc_req_i,
    output MemToCache_t ic_rsp_o,
    output MemToCache_t dc_rsp_o,
    output CacheToMem_t mem_req_o,
    input  MemToCache_t mem_rsp_i,
    output logic        timeout_err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StRespI,
        StRespD
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_last_d, w_last_d_nxt;
    CacheToMem_t r_mem_req, w_mem_req_nxt;
    MemToCache_t r_ic_rsp, w_ic_rsp_nxt;
    MemToCache_t r_dc_rsp, w_dc_rsp_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic        w_grant_i, w_grant_d;

    // On a tie the requester that did not win last time goes first.
    assign w_grant_i = ic_req_i.Valid && (!dc_req_i.Valid || r_last_d);
    assign w_grant_d = dc_req_i.Valid && (!ic_req_i.Valid || !r_last_d);

    always_comb begin
        w_state_nxt   = r_state;
        w_last_d_nxt  = r_last_d;
        w_mem_req_nxt = r_mem_req;
        w_ic_rsp_nxt  = r_ic_rsp;
        w_dc_rsp_nxt  = r_dc_rsp;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;

        unique case (r_state)
            StIdle: begin
                if (w_grant_i) begin
                    w_mem_req_nxt       = ic_req_i;
                    w_mem_req_nxt.Valid = 1'b1;
                    w_last_d_nxt        = 1'b0;
                    w_state_nxt         = StBusyI;
                end else if (w_grant_d) begin
                    w_mem_req_nxt       = dc_req_i;
                    w_mem_req_nxt.Valid = 1'b1;
                    w_last_d_nxt        = 1'b1;
                    w_state_nxt         = StBusyD;
                end
            end
            StBusyI, StBusyD: begin
                if (mem_rsp_i.Ready) begin
                    if (r_state == StBusyI) begin
                        w_ic_rsp_nxt = '{Ready: 1'b1, ReadD: mem_rsp_i.ReadD};
                        w_state_nxt  = StRespI;
                    end else begin
                        w_dc_rsp_nxt = '{Ready: 1'b1, ReadD: mem_rsp_i.ReadD};
                        w_state_nxt  = StRespD;
                    end
                    w_mem_req_nxt.Valid = 1'b0;
                    w_cnt_nxt           = '0;
                end else if (r_cnt != CNT_W'(TIMEOUT)) begin
                    // Saturating wait counter; the error flag is sticky until reset.
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            StRespI: begin
                w_ic_rsp_nxt.Ready = 1'b0;
                w_state_nxt        = StIdle;
            end
            StRespD: begin
                w_dc_rsp_nxt.Ready = 1'b0;
                w_state_nxt        = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_last_d  <= 1'b1;
            r_mem_req <= '0;
            r_ic_rsp  <= '0;
            r_dc_rsp  <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last_d  <= w_last_d_nxt;
            r_mem_req <= w_mem_req_nxt;
            r_ic_rsp  <= w_ic_rsp_nxt;
            r_dc_rsp  <= w_dc_rsp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign mem_req_o     = r_mem_req;
    assign ic_rsp_o      = r_ic_rsp;
    assign dc_rsp_o      = r_dc_rsp;
    assign timeout_err_o = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued at stimulus time and
// checked against mem_req_o grants and the per-cache response pulses.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    CacheToMem_t ic_req, dc_req, mem_req;
    MemToCache_t ic_rsp, dc_rsp, mem_rsp;
    logic        timeout_err;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_req_i     (ic_req),
        .dc_req_i     (dc_req),
        .ic_rsp_o     (ic_rsp),
        .dc_rsp_o     (dc_rsp),
        .mem_req_o    (mem_req),
        .mem_rsp_i    (mem_rsp),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          who;  // 0 = I-cache, 1 = D-cache
        CacheToMem_t req;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        fly_q[$];
    txn_t        mon_e;
    CacheToMem_t cur_req;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rsp = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ic_rdy = 1'b0;
    logic        prev_dc_rdy = 1'b0;
    int          mem_lat = 1;
    bit          mem_en = 1'b1;
    bit          mem_force = 1'b0;
    int          busy_cnt = 0;

    function automatic logic [127:0] rdata_of(logic [31:0] a);
        return {32'hDEADBEEF, ~a, a, 32'h0000_0001};
    endfunction

    function automatic CacheToMem_t mk(logic wen, logic [31:0] a, logic [127:0] d);
        return '{Valid: 1'b1, Wen: wen, Addr: a, WriteD: d};
    endfunction

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(bit who, CacheToMem_t r);
        txn_t t;
        t.who = who;
        t.req = r;
        exp_q.push_back(t);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        fly_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Polls until the response count reaches target, then drops both Valids inside RESP.
    task automatic wait_rsp(int target, int budget);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rsp_wait_bound", 256'(n_rsp >= target), 256'(1));
        ic_req.Valid = 1'b0;
        dc_req.Valid = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Main-memory model: Ready after mem_lat BUSY cycles, data derived from the address.
    initial begin
        mem_rsp = '0;
        forever begin
            @(negedge clk);
            if (mem_req.Valid) busy_cnt++;
            else busy_cnt = 0;
            mem_rsp.Ready = mem_force || (mem_en && mem_req.Valid && busy_cnt >= mem_lat);
            mem_rsp.ReadD = mem_req.Valid ? rdata_of(mem_req.Addr) : 128'hBAD;
        end
    end

    // Monitor: grants and responses are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid  = 1'b0;
            prev_ic_rdy = 1'b0;
            prev_dc_rdy = 1'b0;
        end else begin
            if (mem_req.Valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 256'(1), 256'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("grant_req", 256'(mem_req), 256'(mon_e.req));
                    fly_q.push_back(mon_e);
                    cur_req = mon_e.req;
                end
            end else if (mem_req.Valid) begin
                chk("req_hold", 256'(mem_req), 256'(cur_req));
            end
            if (ic_rsp.Ready || dc_rsp.Ready) begin
                n_rsp++;
                chk("both_ready", 256'(ic_rsp.Ready & dc_rsp.Ready), 256'(0));
                chk("ready_pulse", 256'((ic_rsp.Ready & prev_ic_rdy) | (dc_rsp.Ready & prev_dc_rdy)),
                    256'(0));
                if (fly_q.size() == 0) begin
                    chk("unexpected_rsp", 256'(1), 256'(0));
                end else begin
                    mon_e = fly_q.pop_front();
                    chk("rsp_who", 256'(dc_rsp.Ready), 256'(mon_e.who));
                    chk("rsp_data", 256'(mon_e.who ? dc_rsp.ReadD : ic_rsp.ReadD),
                        256'(rdata_of(mon_e.req.Addr)));
                end
            end
            prev_valid  = mem_req.Valid;
            prev_ic_rdy = ic_rsp.Ready;
            prev_dc_rdy = dc_rsp.Ready;
        end
    end

    initial begin
        CacheToMem_t ri, rd;
        int base, c0;
        rst    = 1'b1;
        ic_req = '0;
        dc_req = '0;
        #12;
        chk("rst_mem_req", 256'(mem_req), 256'(0));
        chk("rst_ic_rsp", 256'(ic_rsp), 256'(0));
        chk("rst_dc_rsp", 256'(dc_rsp), 256'(0));
        chk("rst_err", 256'(timeout_err), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single I-cache read, memory answers after 3 BUSY cycles.
        mem_lat = 3;
        @(negedge clk);
        ri = mk(1'b0, 32'h0000_0100, 128'h0);
        ic_req = ri;
        expect_txn(1'b0, ri);
        base = n_rsp;
        @(negedge clk);
        chk("t1_grant_latency", 256'(mem_req.Valid), 256'(1));
        chk("t1_addr", 256'(mem_req.Addr), 256'(32'h100));
        wait_rsp(base + 1, 20);
        chk("t1_ic_ready", 256'(ic_rsp.Ready), 256'(1));
        chk("t1_dc_ready", 256'(dc_rsp.Ready), 256'(0));
        chk("t1_rdata", 256'(ic_rsp.ReadD), 256'(rdata_of(32'h100)));
        @(negedge clk);
        chk("t1_ready_drop", 256'(ic_rsp.Ready), 256'(0));

        // Both valid from reset: I, D, I, D at 3 cycles per transaction.
        reset_pulse();
        mem_lat = 1;
        ri = mk(1'b0, 32'h0000_1000, 128'h0);
        rd = mk(1'b0, 32'h0000_2000, 128'h0);
        ic_req = ri;
        dc_req = rd;
        expect_txn(1'b0, ri);
        expect_txn(1'b1, rd);
        expect_txn(1'b0, ri);
        expect_txn(1'b1, rd);
        base = n_rsp;
        c0 = cyc;
        wait_rsp(base + 4, 40);
        chk("t2_cycles", 256'(cyc - c0), 256'(11));

        // D-cache write-back; I-cache request arriving mid-BUSY waits its turn.
        mem_lat = 4;
        @(negedge clk);
        rd = mk(1'b1, 32'h0001_0040, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        dc_req = rd;
        expect_txn(1'b1, rd);
        @(negedge clk);
        ri = mk(1'b0, 32'h0000_0300, 128'h0);
        ic_req = ri;
        expect_txn(1'b0, ri);
        dc_req.Valid  = 1'b0;
        dc_req.Addr   = 32'hFFFF_0000;
        dc_req.WriteD = '1;
        base = n_rsp;
        @(negedge clk);
        chk("t3_hold_addr", 256'(mem_req.Addr), 256'(32'h0001_0040));
        chk("t3_hold_wen", 256'(mem_req.Wen), 256'(1));
        wait_rsp(base + 2, 40);
        chk("t3_dc_readd_held", 256'(dc_rsp.ReadD), 256'(rdata_of(32'h0001_0040)));

        // Timeout: memory silent for TO BUSY cycles.
        reset_pulse();
        mem_en = 1'b0;
        @(negedge clk);
        ri = mk(1'b0, 32'h0000_0400, 128'h0);
        ic_req = ri;
        expect_txn(1'b0, ri);
        @(negedge clk);
        ic_req.Valid = 1'b0;
        chk("t4_granted", 256'(mem_req.Valid), 256'(1));
        repeat (TO - 1) @(negedge clk);
        chk("t4_err_before", 256'(timeout_err), 256'(0));
        @(negedge clk);
        chk("t4_err_at", 256'(timeout_err), 256'(1));
        base = n_rsp;
        mem_en = 1'b1;
        wait_rsp(base + 1, 10);
        repeat (2) @(negedge clk);
        chk("t4_err_sticky", 256'(timeout_err), 256'(1));
        reset_pulse();
        chk("t4_err_cleared", 256'(timeout_err), 256'(0));

        // Reset during BUSY_I, then stray memory Ready while IDLE.
        mem_en = 1'b0;
        @(negedge clk);
        ri = mk(1'b0, 32'h0000_0500, 128'h0);
        ic_req = ri;
        expect_txn(1'b0, ri);
        @(negedge clk);
        ic_req.Valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_valid_async", 256'(mem_req.Valid), 256'(0));
        chk("t5_ic_ready", 256'(ic_rsp.Ready), 256'(0));
        fly_q.delete();
        @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;
        mem_force = 1'b1;
        base = n_rsp;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_rsp", 256'(n_rsp), 256'(base));
        chk("t6_ic_ready", 256'(ic_rsp.Ready), 256'(0));
        chk("t6_dc_ready", 256'(dc_rsp.Ready), 256'(0));
        chk("t6_idle", 256'(mem_req.Valid), 256'(0));
        mem_force = 1'b0;

        // Normal traffic still works afterwards.
        mem_lat = 1;
        @(negedge clk);
        rd = mk(1'b0, 32'h0000_0600, 128'h0);
        dc_req = rd;
        expect_txn(1'b1, rd);
        base = n_rsp;
        wait_rsp(base + 1, 20);

        @(negedge clk);
        chk("exp_q_empty", 256'(exp_q.size()), 256'(0));
        chk("fly_q_empty", 256'(fly_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
